seq_bin2bcd: RTL and testbench

Sequential double-dabble binary-to-BCD converter for the FIR machine display path. Sits downstream of the binary result and calculation counters and upstream of the seven-segment digit pager: it converts a WIDTH-bit unsigned value into DIGITS packed BCD digits using one shift per clock. A start/busy/done handshake lets the pager request a fresh conversion once per display page. The output holds stable between conversions.

---
 rtl/seq_bin2bcd.sv | 74 +++++++
 tb/tb_seq_bin2bcd.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seq_bin2bcd.sv
// seq_bin2bcd: sequential double-dabble binary-to-BCD converter, one shift per clock.
// Define BCD_SATURATE_EN to force an overflowed result to all nines instead of truncating.
module seq_bin2bcd #(
  parameter int WIDTH  = 30,
  parameter int DIGITS = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0] work, adj, res;
  logic sticky;
  logic [CW-1:0] cnt;
  genvar d;
  generate
    for (d = 0; d < DIGITS; d++) begin : g_adj
      assign adj[4*d+:4] = (work[4*d+:4] >= 4'd5) ? work[4*d+:4] + 4'd3 : work[4*d+:4];
    end
  endgenerate
`ifdef BCD_SATURATE_EN
  assign res = sticky ? {DIGITS{4'h9}} : work;
`else
  assign res = work;
`endif
  assign busy = (state != IDLE);
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && start) ? SHIFT : state_nx;
    state_nx = (state == SHIFT && cnt == CW'(WIDTH - 1)) ? FINISH : state_nx;
    state_nx = (state == FINISH) ? IDLE : state_nx;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  // A carry out of the top digit means the value no longer fits in DIGITS digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      work     <= '0;
      sticky   <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= (state == FINISH);
      if (state == IDLE && start) begin
        shreg  <= bin;
        work   <= '0;
        sticky <= 1'b0;
        cnt    <= '0;
      end
      if (state == SHIFT) begin
        {work, shreg} <= {adj[BW-2:0], shreg, 1'b0};
        sticky        <= sticky | adj[BW-1];
        cnt           <= cnt + 1'b1;
      end
      if (state == FINISH) begin
        bcd      <= res;
        overflow <= sticky;
      end
    end
  end
endmodule

// File: tb/tb_seq_bin2bcd.sv
// tb_seq_bin2bcd: table-driven and randomized checks of seq_bin2bcd against an arithmetic model.
module tb_seq_bin2bcd;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [29:0] bin = '0;
  logic busy, done, overflow;
  logic [35:0] bcd;
  int n_cmp = 0;
  int n_fail = 0;

  seq_bin2bcd #(.WIDTH(30), .DIGITS(9)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] b;
    logic [35:0] e;
    logic        o;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: decimal digits by repeated division, overflow when beyond nine digits.
  function automatic logic [36:0] model(input longint v);
    logic [35:0] r;
    logic o;
    o = (v > 64'd999999999);
    for (int i = 0; i < 9; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
`ifdef BCD_SATURATE_EN
    if (o) r = 36'h999999999;
`endif
    return {o, r};
  endfunction

  task automatic convert(input logic [29:0] b, input string nm, input logic [35:0] eb, input logic eo);
    int lat;
    @(posedge clk); #1;
    bin = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bin = '0;
    chk({nm, " busy after accept"}, longint'(busy), 1);
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, lat, 31);
    chk({nm, " bcd"}, longint'(bcd), longint'(eb));
    chk({nm, " overflow"}, longint'(overflow), longint'(eo));
    chk({nm, " busy at done"}, longint'(busy), 0);
    @(posedge clk); #1;
    chk({nm, " done pulse width"}, longint'(done), 0);
    chk({nm, " bcd held"}, longint'(bcd), longint'(eb));
  endtask

  vec_t tbl[9];
  logic [36:0] m;
  logic [29:0] rv;
  int lat, pulses;
  int pos[$];

  initial begin
    tbl[0] = '{30'd0,          36'h000000000, 1'b0};
    tbl[1] = '{30'd123456789,  36'h123456789, 1'b0};
    tbl[2] = '{30'd999999999,  36'h999999999, 1'b0};
`ifdef BCD_SATURATE_EN
    tbl[3] = '{30'd1073741823, 36'h999999999, 1'b1};
    tbl[4] = '{30'd1000000000, 36'h999999999, 1'b1};
`else
    tbl[3] = '{30'd1073741823, 36'h073741823, 1'b1};
    tbl[4] = '{30'd1000000000, 36'h000000000, 1'b1};
`endif
    tbl[5] = '{30'd42,         36'h000000042, 1'b0};
    tbl[6] = '{30'd5,          36'h000000005, 1'b0};
    tbl[7] = '{30'd10,         36'h000000010, 1'b0};
    tbl[8] = '{30'd500000000,  36'h500000000, 1'b0};

    #1;
    chk("reset busy", longint'(busy), 0);
    chk("reset done", longint'(done), 0);
    chk("reset bcd", longint'(bcd), 0);
    chk("reset overflow", longint'(overflow), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle no start", longint'(busy), 0);

    for (int i = 0; i < 9; i++)
      convert(tbl[i].b, $sformatf("vec%0d", i), tbl[i].e, tbl[i].o);

    for (int i = 0; i < 20; i++) begin
      rv = (i % 2 == 0) ? 30'($urandom) : 30'($urandom_range(0, 999999999));
      m = model(longint'(rv));
      convert(rv, $sformatf("rand%0d", i), m[35:0], m[36]);
    end

    // A second start mid-conversion must be ignored and not queued.
    @(posedge clk); #1;
    bin = 30'd321; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bin = '0;
    lat = 0; pulses = 0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 10) begin start = 1'b1; bin = 30'd999; end
      if (c == 11) begin start = 1'b0; bin = '0; end
      @(posedge clk); #1;
      if (done) begin pulses++; lat = c; end
    end
    chk("ignored start pulses", pulses, 1);
    chk("ignored start latency", lat, 31);
    chk("ignored start bcd", longint'(bcd), 36'h000000321);

    // Held start yields back-to-back conversions every 32 clocks.
    @(posedge clk); #1;
    bin = 30'd42; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 96; c++) begin
      @(posedge clk); #1;
      if (done) begin
        pos.push_back(c);
        chk($sformatf("held bcd at %0d", c), longint'(bcd), 36'h000000042);
      end
    end
    start = 1'b0;
    chk("held pulse count", pos.size(), 3);
    if (pos.size() == 3) begin
      chk("held done 1", pos[0], 31);
      chk("held done 2", pos[1], 63);
      chk("held done 3", pos[2], 95);
    end
    lat = 0;
    while (busy && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("held drain", longint'(busy), 0);
    @(posedge clk); #1;

    // Reset mid-conversion discards the result.
    convert(30'd123, "pre-reset", 36'h000000123, 1'b0);
    bin = 30'd555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bin = '0;
    repeat (14) @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst busy", longint'(busy), 0);
    chk("midrst done", longint'(done), 0);
    chk("midrst bcd", longint'(bcd), 0);
    chk("midrst overflow", longint'(overflow), 0);
    @(posedge clk); #1 rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("no done after reset", pulses, 0);
    convert(30'd7, "post-reset", 36'h000000007, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
